// File: rtl/shifter_arb_pkg.sv
// Shared types, default sizing and small helpers for the shifter arbiter slice.
// The structs describe the default-configuration request/response layout.
package shifter_arb_pkg;

    localparam int DEF_WIDTH       = 64;
    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_SHIFT_WIDTH = $clog2(DEF_WIDTH);
    localparam int DEF_ID_WIDTH    = $clog2(DEF_NUM_REQ);

    typedef struct packed {
        logic [DEF_WIDTH-1:0]       data;
        logic [DEF_SHIFT_WIDTH-1:0] shift;
        logic                       rotate;
        logic                       right;
        logic [DEF_ID_WIDTH-1:0]    id;
    } shift_op_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]    data;
        logic [DEF_ID_WIDTH-1:0] id;
    } shift_rsp_t;

    // Increment with wrap back to zero at n (n need not be a power of two).
    function automatic int wrap_inc(int v, int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/BarrelShifter.sv
// Logarithmic left shifter/rotator; right operations reuse it by reversing
// the operand on the way in and the result on the way out.
module BarrelShifter #(
    parameter int W  = 64,
    parameter int SW = $clog2(W)
) (
    input  logic [W-1:0]  data_in,
    input  logic [SW-1:0] shift_amt,
    input  logic          shift_rotate,
    input  logic          left_right,
    output logic [W-1:0]  data_out
);

    function automatic logic [W-1:0] bit_rev(logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    logic [W-1:0] stg [SW+1];

    assign stg[0] = left_right ? bit_rev(data_in) : data_in;

    for (genvar s = 0; s < SW; s++) begin : g_stage
        localparam int D = 1 << s;
        logic [W-1:0] sh_v;
        assign sh_v = shift_rotate ? {stg[s][W-1-D:0], stg[s][W-1 -: D]}
                                   : {stg[s][W-1-D:0], {D{1'b0}}};
        assign stg[s+1] = shift_amt[s] ? sh_v : stg[s];
    end

    assign data_out = left_right ? bit_rev(stg[SW]) : stg[SW];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps; the
// pointer value for the next cycle is winner+1 when advance is set.
module rr_arbiter
    import shifter_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic [IW-1:0] ptr_next
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    assign ptr_next = advance ? IW'(wrap_inc(int'(idx), N)) : ptr;

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin front end and two-stage pipeline sharing one BarrelShifter
// between NUM_REQ requesters; results leave tagged with the requester index.
module shifter_arbiter
    import shifter_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SHIFT_WIDTH = $clog2(WIDTH),
    parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]       req_data,
    input  logic [NUM_REQ*SHIFT_WIDTH-1:0] req_shift,
    input  logic [NUM_REQ-1:0]             req_rotate,
    input  logic [NUM_REQ-1:0]             req_right,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [WIDTH-1:0]               rsp_data,
    output logic [ID_WIDTH-1:0]            rsp_id
);

    logic                   s1_valid;
    logic [WIDTH-1:0]       s1_data;
    logic [SHIFT_WIDTH-1:0] s1_shift;
    logic                   s1_rotate;
    logic                   s1_right;
    logic [ID_WIDTH-1:0]    s1_id;

    logic                   s2_valid;
    logic [WIDTH-1:0]       s2_data;
    logic [ID_WIDTH-1:0]    s2_id;

    logic                   s1_free;
    logic                   s2_free;
    logic                   any_req;
    logic                   accept;
    logic [NUM_REQ-1:0]     grant;
    logic [ID_WIDTH-1:0]    win_idx;
    logic [ID_WIDTH-1:0]    rr_ptr;
    logic [ID_WIDTH-1:0]    rr_ptr_next;
    logic [WIDTH-1:0]       shift_out;

    assign s2_free = !s2_valid || rsp_ready;
    assign s1_free = !s1_valid || s2_free;
    assign any_req = |req_valid;
    assign accept  = any_req && s1_free;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_WIDTH)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .advance  (accept),
        .grant    (grant),
        .idx      (win_idx),
        .ptr_next (rr_ptr_next)
    );

    // Held low during reset so nothing appears accepted while the pipe is cleared.
    assign req_ready = (rst_n && s1_free) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_shift  <= '0;
            s1_rotate <= 1'b0;
            s1_right  <= 1'b0;
            s1_id     <= '0;
        end else if (s1_free) begin
            s1_valid <= any_req;
            if (any_req) begin
                s1_data   <= req_data[win_idx*WIDTH +: WIDTH];
                s1_shift  <= req_shift[win_idx*SHIFT_WIDTH +: SHIFT_WIDTH];
                s1_rotate <= req_rotate[win_idx];
                s1_right  <= req_right[win_idx];
                s1_id     <= win_idx;
            end
        end
    end

    BarrelShifter #(
        .W  (WIDTH),
        .SW (SHIFT_WIDTH)
    ) u_shifter (
        .data_in      (s1_data),
        .shift_amt    (s1_shift),
        .shift_rotate (s1_rotate),
        .left_right   (s1_right),
        .data_out     (shift_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= shift_out;
                s2_id   <= s1_id;
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_data  = s2_data;
    assign rsp_id    = s2_id;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter (WIDTH=8, NUM_REQ=4): directed
// scenarios plus randomized traffic against a queue-based reference model.
module tb_shifter_arbiter;

    localparam int W  = 8;
    localparam int NR = 4;
    localparam int SW = 3;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_data;
    logic [NR*SW-1:0]  req_shift;
    logic [NR-1:0]     req_rotate;
    logic [NR-1:0]     req_right;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [IW-1:0]     rsp_id;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_ptr = 0;
    logic [W-1:0] q_data[$];
    int          q_id[$];
    int          wait_cnt[NR];
    int          max_wait = 0;

    // per-cycle observation vs model expectation
    logic [NR-1:0] exp_ready, obs_ready, obs_acc;
    bit            obs_fire, obs_rvalid, exp_head_ok;
    logic [W-1:0]  obs_rdata, exp_rdata;
    int            obs_rid, exp_rid;

    shifter_arbiter #(
        .NUM_REQ     (NR),
        .WIDTH       (W),
        .SHIFT_WIDTH (SW),
        .ID_WIDTH    (IW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_shift  (req_shift),
        .req_rotate (req_rotate),
        .req_right  (req_right),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_shift(logic [W-1:0] d, logic [SW-1:0] s, logic rot, logic rt);
        int v = int'(d);
        int n = int'(s) % W;
        int r;
        if (n == 0) return d;
        if (!rt) r = rot ? ((v << n) | (v >> (W - n))) : (v << n);
        else     r = rot ? ((v >> n) | (v << (W - n))) : (v >> n);
        return W'(r & ((1 << W) - 1));
    endfunction

    task automatic set_req(int i, logic [W-1:0] d, logic [SW-1:0] s, logic rot, logic rt);
        req_data[i*W +: W]    = d;
        req_shift[i*SW +: SW] = s;
        req_rotate[i]         = rot;
        req_right[i]          = rt;
        req_valid[i]          = 1'b1;
    endtask

    task automatic set_rand_req(int i);
        set_req(i, W'($urandom), SW'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_accepted();
        req_valid = req_valid & ~obs_acc;
    endtask

    task automatic model_clear();
        q_data.delete();
        q_id.delete();
        m_ptr = 0;
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    endtask

    // Samples the DUT at the falling edge and advances the reference model
    // for the rising edge that follows.
    task automatic observe();
        int  w;
        bit  any, free;
        @(negedge clk);
        any = |req_valid;
        free = (q_data.size() < 2) || rsp_ready;
        w = -1;
        for (int k = 0; k < NR; k++) begin
            int c = (m_ptr + k) % NR;
            if (w < 0 && req_valid[c]) w = c;
        end
        exp_ready = '0;
        if (any && free) exp_ready[w] = 1'b1;
        obs_ready  = req_ready;
        obs_acc    = req_valid & req_ready;
        obs_rvalid = rsp_valid;
        obs_fire   = rsp_valid && rsp_ready;
        obs_rdata  = rsp_data;
        obs_rid    = int'(rsp_id);
        exp_head_ok = 1'b0;
        if (obs_fire && q_data.size() > 0) begin
            exp_head_ok = 1'b1;
            exp_rdata   = q_data.pop_front();
            exp_rid     = q_id.pop_front();
        end
        if (any && free) begin
            q_data.push_back(ref_shift(req_data[w*W +: W], req_shift[w*SW +: SW], req_rotate[w], req_right[w]));
            q_id.push_back(w);
            m_ptr = (w + 1) % NR;
        end
        for (int i = 0; i < NR; i++) begin
            if (obs_acc[i]) wait_cnt[i] = 0;
            else if (req_valid[i] && |obs_acc) begin
                wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        for (int i = 0; i < NR; i++) set_req(i, 8'hA5, 3'd1, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        #12;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        req_valid = '0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        to_drive();
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        set_req(0, 8'h81, 3'd1, 1'b1, 1'b0);
        observe();
        checks++; if (obs_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", obs_ready); end
        to_drive();
        drop_accepted();
        observe();
        checks++; if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL single_early: rsp_valid %b one cycle after accept, want 0", obs_rvalid); end
        to_drive();
        observe();
        checks++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 8'h03 || obs_rid != 0) begin
            errors++; $display("FAIL single_rsp: valid %b data %h id %0d, want 1 03 0", obs_rvalid, obs_rdata, obs_rid);
        end
        to_drive();
        observe();
        checks++; if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL single_after: rsp_valid %b want 0", obs_rvalid); end
        to_drive();
    endtask

    task automatic test_direction();
        int       t_req[3] = '{2, 1, 3};
        logic [7:0] t_d[3] = '{8'h81, 8'h81, 8'h5A};
        logic [2:0] t_s[3] = '{3'd1, 3'd3, 3'd0};
        logic     t_rot[3] = '{1'b1, 1'b0, 1'b0};
        logic     t_rt[3]  = '{1'b1, 1'b1, 1'b0};
        logic [7:0] t_e[3] = '{8'hC0, 8'h10, 8'h5A};
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(t_req[k], t_d[k], t_s[k], t_rot[k], t_rt[k]);
            observe();
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL dir_ready[%0d]: got %b want %b", k, obs_ready, exp_ready); end
            to_drive();
            drop_accepted();
            observe();
            to_drive();
            observe();
            checks++;
            if (obs_rvalid !== 1'b1 || obs_rdata !== t_e[k] || obs_rid != t_req[k]) begin
                errors++; $display("FAIL dir_rsp[%0d]: valid %b data %h id %0d, want 1 %h %0d", k, obs_rvalid, obs_rdata, obs_rid, t_e[k], t_req[k]);
            end
            to_drive();
        end
    endtask

    task automatic test_fairness();
        int order[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_rand_req(i);
        for (int k = 0; k < 12; k++) begin
            if (k == 8) req_valid[1] = 1'b0;
            observe();
            checks++;
            if (obs_acc !== (4'b0001 << order[k]) || obs_ready !== exp_ready) begin
                errors++; $display("FAIL fair_grant[%0d]: got %b want %b", k, obs_acc, 4'b0001 << order[k]);
            end
            if (obs_fire) begin
                checks++;
                if (!exp_head_ok || obs_rdata !== exp_rdata || obs_rid != exp_rid) begin
                    errors++; $display("FAIL fair_rsp: data %h id %0d, want %h %0d", obs_rdata, obs_rid, exp_rdata, exp_rid);
                end
            end
            to_drive();
            for (int i = 0; i < NR; i++) if (obs_acc[i]) set_rand_req(i);
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            observe();
            if (obs_fire) begin
                checks++;
                if (!exp_head_ok || obs_rdata !== exp_rdata || obs_rid != exp_rid) begin
                    errors++; $display("FAIL fair_drain: data %h id %0d, want %h %0d", obs_rdata, obs_rid, exp_rdata, exp_rid);
                end
            end
            to_drive();
        end
        checks++; if (q_data.size() != 0) begin errors++; $display("FAIL fair_lost: %0d responses missing, want 0", q_data.size()); end
    endtask

    task automatic test_backpressure();
        int           n_acc = 0;
        int           n_fire = 0;
        bit           held = 1'b0;
        logic [W-1:0] hold_d;
        int           hold_id = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) set_rand_req(i);
        for (int k = 0; k < 6; k++) begin
            observe();
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL bp_ready[%0d]: got %b want %b", k, obs_ready, exp_ready); end
            n_acc += $countones(obs_acc);
            if (obs_rvalid) begin
                if (held) begin
                    checks++;
                    if (obs_rdata !== hold_d || obs_rid != hold_id) begin
                        errors++; $display("FAIL bp_stable: data %h id %0d, want %h %0d", obs_rdata, obs_rid, hold_d, hold_id);
                    end
                end
                held = 1'b1; hold_d = obs_rdata; hold_id = obs_rid;
            end
            to_drive();
            drop_accepted();
        end
        checks++; if (n_acc != 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", n_acc); end
        checks++; if (obs_ready !== '0) begin errors++; $display("FAIL bp_blocked: req_ready %b want 0000", obs_ready); end
        rsp_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            observe();
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL bp_rel_ready[%0d]: got %b want %b", k, obs_ready, exp_ready); end
            if (obs_fire) begin
                if (k < 4) n_fire++;
                checks++;
                if (!exp_head_ok || obs_rdata !== exp_rdata || obs_rid != exp_rid) begin
                    errors++; $display("FAIL bp_rsp: data %h id %0d, want %h %0d", obs_rdata, obs_rid, exp_rdata, exp_rid);
                end
            end
            to_drive();
            drop_accepted();
        end
        checks++; if (n_fire != 4) begin errors++; $display("FAIL bp_rate: %0d responses in 4 cycles, want 4", n_fire); end
        checks++; if (q_data.size() != 0) begin errors++; $display("FAIL bp_lost: %0d responses missing, want 0", q_data.size()); end
    endtask

    task automatic test_reset_midflight();
        int n_acc = 0;
        int n_fire = 0;
        rsp_ready = 1'b0;
        set_rand_req(0);
        set_rand_req(2);
        for (int k = 0; k < 6 && n_acc < 2; k++) begin
            observe();
            n_acc += $countones(obs_acc);
            to_drive();
            drop_accepted();
        end
        checks++; if (n_acc != 2) begin errors++; $display("FAIL rst_fill: got %0d accepts want 2", n_acc); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0) begin
            errors++; $display("FAIL rst_async: valid %b data %h id %0d, want 0 00 0", rsp_valid, rsp_data, rsp_id);
        end
        set_rand_req(1);
        set_rand_req(3);
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        req_valid = '0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        to_drive();
        rsp_ready = 1'b1;
        set_rand_req(1);
        set_rand_req(3);
        for (int k = 0; k < 6; k++) begin
            observe();
            if (k == 0) begin
                checks++; if (obs_ready !== 4'b0010) begin errors++; $display("FAIL rst_first_grant: got %b want 0010", obs_ready); end
            end
            if (obs_fire) begin
                n_fire++;
                checks++;
                if (!exp_head_ok || obs_rdata !== exp_rdata || obs_rid != exp_rid) begin
                    errors++; $display("FAIL rst_rsp: data %h id %0d, want %h %0d", obs_rdata, obs_rid, exp_rdata, exp_rid);
                end
            end
            to_drive();
            drop_accepted();
        end
        checks++; if (n_fire != 2) begin errors++; $display("FAIL rst_stale: got %0d responses want 2", n_fire); end
    endtask

    task automatic test_random();
        int n_acc = 0;
        int cyc = 0;
        max_wait = 0;
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
        obs_acc = '0;
        req_valid = '0;
        while (n_acc < 10000 && cyc < 40000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                if (obs_acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 1) != 0) set_rand_req(i);
                    else req_valid[i] = 1'b0;
                end
            end
            observe();
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, obs_ready, exp_ready); end
            if (obs_fire) begin
                checks++;
                if (!exp_head_ok || obs_rdata !== exp_rdata || obs_rid != exp_rid) begin
                    errors++; $display("FAIL rnd_rsp@%0d: data %h id %0d, want %h %0d", cyc, obs_rdata, obs_rid, exp_rdata, exp_rid);
                end
            end
            n_acc += $countones(obs_acc);
            cyc++;
            to_drive();
        end
        checks++; if (n_acc < 10000) begin errors++; $display("FAIL rnd_budget: %0d accepts in %0d cycles, want 10000", n_acc, cyc); end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && q_data.size() > 0; k++) begin
            observe();
            if (obs_fire) begin
                checks++;
                if (!exp_head_ok || obs_rdata !== exp_rdata || obs_rid != exp_rid) begin
                    errors++; $display("FAIL rnd_drain: data %h id %0d, want %h %0d", obs_rdata, obs_rid, exp_rdata, exp_rid);
                end
            end
            to_drive();
        end
        checks++; if (q_data.size() != 0) begin errors++; $display("FAIL rnd_lost: %0d responses missing, want 0", q_data.size()); end
        checks++; if (max_wait > NR - 1) begin errors++; $display("FAIL rnd_starve: max wait %0d accepts, want <= %0d", max_wait, NR - 1); end
    endtask

    initial begin
        req_valid  = '0;
        req_data   = '0;
        req_shift  = '0;
        req_rotate = '0;
        req_right  = '0;
        rsp_ready  = 1'b1;
        obs_acc    = '0;
        test_reset();
        test_single();
        test_direction();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
